// File: rtl/sbox_pkg.sv
// Shared constants and FSM encoding for the inverse S-box builder.
// The ERROR state only exists when SBOX_INV_CHECK_EN is defined.
package sbox_pkg;
   localparam int SBOX_W     = 8;
   localparam int SBOX_DEPTH = 256;

`ifdef SBOX_INV_CHECK_EN
   typedef enum logic [1:0] {IDLE, LOAD, SERVE, ERROR} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;
`endif
endpackage

// File: rtl/sbox_inv_if.sv
// Byte-stream handshake bundle: cipher bytes in, plain bytes out.
interface sbox_inv_if
   import sbox_pkg::*;
#(
   parameter int DATA_W = SBOX_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/sbox_inv_ram.sv
// Inverse table storage: one synchronous write port, one registered read port.
module sbox_inv_ram
   import sbox_pkg::*;
#(
   parameter int DATA_W = SBOX_W,
   parameter int DEPTH  = SBOX_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents deliberately survive reset; every rebuild rewrites all entries.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/sbox_inv.sv
// Builds inv[sbox[i]] = i from a forward S-box, then serves byte lookups.
// Define SBOX_INV_CHECK_EN to add the permutation check and ERROR state.
module sbox_inv
   import sbox_pkg::*;
#(
   parameter int DATA_W = SBOX_W,
   parameter int DEPTH  = SBOX_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done_sbox,
   output logic [DATA_W-1:0] sbox_raddr,
   input  logic [DATA_W-1:0] sbox_rdata,
   output logic              busy,
   output logic              inv_ready,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              err
);
   localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] raddr_q, raddr_d;
   logic [DATA_W-1:0] waddr_q, waddr_d;
   logic              rd_pend_q, rd_pend_d;
   logic              issue_done_q, issue_done_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   logic              wr_en, last_write, accept;
   logic [DATA_W-1:0] ram_rdata;
`ifdef SBOX_INV_CHECK_EN
   logic [DEPTH-1:0]  seen_q, seen_d;
   logic              dup_hit;

   assign dup_hit = wr_en && seen_q[sbox_rdata];
`endif

   assign wr_en      = (state_q == LOAD) && rd_pend_q;
   assign last_write = wr_en && (waddr_q == LAST_ADDR);
   assign busy       = (state_q == LOAD);
   assign inv_ready  = (state_q == SERVE);
   assign in_ready   = inv_ready && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      raddr_d      = raddr_q;
      waddr_d      = waddr_q;
      rd_pend_d    = 1'b0;
      issue_done_d = issue_done_q;
      out_valid_d  = out_valid_q;
      err_d        = err_q;
`ifdef SBOX_INV_CHECK_EN
      seen_d       = seen_q;
`endif
      case (state_q)
         IDLE: begin
            if (done_sbox) begin
               state_d      = LOAD;
               raddr_d      = '0;
               issue_done_d = 1'b0;
`ifdef SBOX_INV_CHECK_EN
               seen_d       = '0;
`endif
            end
         end
         LOAD: begin
            // Address k is issued in cycle k and written in cycle k+1.
            if (!issue_done_q) begin
               rd_pend_d = 1'b1;
               waddr_d   = raddr_q;
               if (raddr_q == LAST_ADDR) issue_done_d = 1'b1;
               else                      raddr_d      = raddr_q + DATA_W'(1);
            end
            if (last_write) begin
               state_d = SERVE;
               raddr_d = '0;
            end
`ifdef SBOX_INV_CHECK_EN
            if (wr_en) seen_d[sbox_rdata] = 1'b1;
            if (dup_hit) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end
`endif
         end
         SERVE: begin
            if (accept)         out_valid_d = 1'b1;
            else if (out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         raddr_q      <= '0;
         waddr_q      <= '0;
         rd_pend_q    <= 1'b0;
         issue_done_q <= 1'b0;
         out_valid_q  <= 1'b0;
         err_q        <= 1'b0;
`ifdef SBOX_INV_CHECK_EN
         seen_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         raddr_q      <= raddr_d;
         waddr_q      <= waddr_d;
         rd_pend_q    <= rd_pend_d;
         issue_done_q <= issue_done_d;
         out_valid_q  <= out_valid_d;
         err_q        <= err_d;
`ifdef SBOX_INV_CHECK_EN
         seen_q       <= seen_d;
`endif
      end
   end

   sbox_inv_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (sbox_rdata),
      .wdata (waddr_q),
      .re    (accept),
      .raddr (in_data),
      .rdata (ram_rdata)
   );

   // The RAM read register has no reset, so gate it while nothing is valid.
   assign out_valid  = out_valid_q;
   assign out_data   = out_valid_q ? ram_rdata : '0;
   assign sbox_raddr = raddr_q;
   assign err        = err_q;
endmodule

// File: tb/tb_sbox_inv.sv
// Randomised bench for sbox_inv: forward table model, inverse reference and
// an expected-output queue; prints one line per output transfer.
module tb_sbox_inv;
   localparam int W = 8;
   localparam int N = 256;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         done_sbox = 1'b0;
   logic [W-1:0] sbox_raddr;
   logic [W-1:0] sbox_rdata = '0;
   logic         busy, inv_ready, err;

   sbox_inv_if #(.DATA_W(W)) hs();

   logic [W-1:0] fwd   [N];
   logic [W-1:0] inv_m [N];
   logic [W-1:0] exp_q [$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_in_fire = 0;
   int           n_out_fire = 0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] held_data = '0;

   always #5 clk = ~clk;

   // Forward S-box source: data valid one cycle after the address.
   always @(posedge clk) sbox_rdata <= fwd[sbox_raddr];

   sbox_inv #(.DATA_W(W), .DEPTH(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .done_sbox  (done_sbox),
      .sbox_raddr (sbox_raddr),
      .sbox_rdata (sbox_rdata),
      .busy       (busy),
      .inv_ready  (inv_ready),
      .in_valid   (hs.in_valid),
      .in_ready   (hs.in_ready),
      .in_data    (hs.in_data),
      .out_valid  (hs.out_valid),
      .out_ready  (hs.out_ready),
      .out_data   (hs.out_data),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference inverse: the last forward index mapping to a value wins.
   task automatic build_model();
      for (int i = 0; i < N; i++) inv_m[fwd[i]] = W'(i);
   endtask

   task automatic random_perm();
      logic [W-1:0] t;
      int j;
      for (int i = 0; i < N; i++) fwd[i] = W'(i);
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = fwd[i]; fwd[i] = fwd[j]; fwd[j] = t;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; done_sbox = 1'b0;
      hs.in_valid = 1'b0; hs.in_data = '0; hs.out_ready = 1'b0;
      exp_q.delete();
      stall_prev = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_table();
      int cnt = 0;
      int bad = 0;
      done_sbox = 1'b1;
      for (int g = 0; g < 600; g++) begin
         @(negedge clk);
         if (busy) begin
            if (cnt < N && sbox_raddr != W'(cnt)) bad++;
            cnt++;
         end else if (cnt > 0) break;
      end
      check("load_len", cnt, 257);
      check("load_raddr_seq", bad, 0);
      check("load_inv_ready", inv_ready, 1);
      check("load_err", err, 0);
   endtask

   // Drive one cycle; score transfers that the next rising edge will perform.
   task automatic tick(input logic iv, input logic [W-1:0] id, input logic ordy);
      logic [W-1:0] e;
      hs.in_valid = iv; hs.in_data = id; hs.out_ready = ordy;
      #1;
      if (stall_prev) begin
         check("hold_valid", hs.out_valid, 1);
         check("hold_data", hs.out_data, held_data);
      end
      stall_prev = hs.out_valid && !hs.out_ready;
      held_data  = hs.out_data;
      if (hs.out_valid && hs.out_ready) begin
         n_out_fire++;
         if (exp_q.size() == 0) check("spurious_out", 1, 0);
         else begin
            e = exp_q.pop_front();
            $display("xfer %0d: out=%02h expected=%02h", n_out_fire, hs.out_data, e);
            check("out_data", hs.out_data, e);
         end
      end
      if (hs.in_valid && hs.in_ready) begin
         n_in_fire++;
         exp_q.push_back(inv_m[hs.in_data]);
      end
      @(negedge clk);
   endtask

   task automatic random_traffic(input int cycles);
      for (int i = 0; i < cycles; i++)
         tick($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
      repeat (4) tick(1'b0, '0, 1'b1);
      check("drain_empty", exp_q.size(), 0);
      check("drain_balance", n_out_fire, n_in_fire);
   endtask

   initial begin
      int bad;
      int g;
      hs.in_valid = 1'b0; hs.in_data = '0; hs.out_ready = 1'b0;
      for (int i = 0; i < N; i++) fwd[i] = W'(i);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_raddr", sbox_raddr, 0);
      check("rst_busy", busy, 0);
      check("rst_inv_ready", inv_ready, 0);
      check("rst_in_ready", hs.in_ready, 0);
      check("rst_out_valid", hs.out_valid, 0);
      check("rst_out_data", hs.out_data, 0);
      check("rst_err", err, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);

      // Identity table
      build_model();
      load_table();
      tick(1'b1, 8'h37, 1'b1);
      check("lat_valid", hs.out_valid, 1);
      check("lat_data", hs.out_data, 8'h37);
      tick(1'b0, '0, 1'b1);
      check("drop_valid", hs.out_valid, 0);

      // XOR A5 table: singles, then a full-rate burst
      do_reset();
      for (int i = 0; i < N; i++) fwd[i] = W'(i) ^ 8'hA5;
      build_model();
      load_table();
      tick(1'b1, 8'h00, 1'b1);
      check("xor_00", hs.out_data, 8'hA5);
      tick(1'b1, 8'hFF, 1'b1);
      check("xor_ff", hs.out_data, 8'h5A);
      tick(1'b0, '0, 1'b1);
      n_in_fire = 0; n_out_fire = 0;
      for (int i = 0; i < N; i++) tick(1'b1, W'(i), 1'b1);
      tick(1'b0, '0, 1'b1);
      check("burst_in", n_in_fire, 256);
      check("burst_out", n_out_fire, 256);
      check("burst_end_valid", hs.out_valid, 0);

      // Backpressure
      n_in_fire = 0; n_out_fire = 0;
      tick(1'b1, 8'h11, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 8'h22, 1'b0);
         check("bp_in_ready", hs.in_ready, 0);
         check("bp_data", hs.out_data, inv_m[8'h11]);
      end
      tick(1'b1, 8'h22, 1'b1);
      tick(1'b1, 8'h33, 1'b1);
      repeat (2) tick(1'b0, '0, 1'b1);
      check("bp_in_count", n_in_fire, 3);
      check("bp_out_count", n_out_fire, 3);
      check("bp_empty", exp_q.size(), 0);

      // Random permutation and random handshakes
      do_reset();
      random_perm();
      build_model();
      load_table();
      n_in_fire = 0; n_out_fire = 0;
      random_traffic(500);

      // done_sbox toggling while serving
      done_sbox = 1'b0;
      repeat (3) @(negedge clk);
      done_sbox = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || !inv_ready) bad++;
      end
      check("serve_stays", bad, 0);
      n_in_fire = 0; n_out_fire = 0;
      random_traffic(100);

      // Reset in the middle of a load, then a full rebuild
      do_reset();
      random_perm();
      build_model();
      done_sbox = 1'b1;
      g = 0;
      while (!(busy && sbox_raddr == 8'd100) && g < 400) begin
         @(negedge clk);
         g++;
      end
      check("reach_addr_100", sbox_raddr, 100);
      rst = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_raddr", sbox_raddr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      load_table();
      n_in_fire = 0; n_out_fire = 0;
      random_traffic(300);

      // Duplicate forward entries: sbox[3] = sbox[7] = 8'h10
      do_reset();
      for (int i = 0; i < N; i++) fwd[i] = W'(i);
      fwd[3] = 8'h10; fwd[7] = 8'h10; fwd[16] = 8'h03;
      build_model();
`ifdef SBOX_INV_CHECK_EN
      done_sbox = 1'b1;
      repeat (9) @(negedge clk);
      check("dup_pre_err", err, 0);
      check("dup_pre_busy", busy, 1);
      @(negedge clk);
      check("dup_err", err, 1);
      check("dup_busy", busy, 0);
      check("dup_inv_ready", inv_ready, 0);
      hs.in_valid = 1'b1; hs.out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         done_sbox = i[2];
         @(negedge clk);
         if (!err || busy || inv_ready || hs.in_ready || hs.out_valid) bad++;
      end
      check("dup_stays_error", bad, 0);
      hs.in_valid = 1'b0;
`else
      load_table();
      check("dup_no_err", err, 0);
      tick(1'b1, 8'h10, 1'b1);
      check("dup_last_wins", hs.out_data, 8'h07);
      tick(1'b0, '0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
